// File: rtl/lfsr_encrypt_engine_pkg.sv
// Shared types and constants for the LFSR encryption stage: FSM states,
// data-memory map, and the maximal-length tap patterns.
package enc_pkg;

    typedef enum logic [2:0] {IDLE, CFG0, CFG1, CFG2, ENC, DONE} state_t;

    localparam logic [7:0] MSG_BASE = 8'd0;
    localparam logic [7:0] CFG_PRE  = 8'd61;
    localparam logic [7:0] CFG_PTRN = 8'd62;
    localparam logic [7:0] CFG_INIT = 8'd63;
    localparam logic [7:0] OUT_BASE = 8'd64;

    localparam int         NUM_OUT  = 64;
    localparam logic [6:0] LAST_IDX = 7'(NUM_OUT - 1);
    localparam logic [6:0] MAX_MSG  = 7'd49;
    localparam logic [3:0] PRE_MIN  = 4'd10;
    localparam logic [7:0] SPACE    = 8'h20;

    localparam int         NUM_TAPS = 9;
    localparam logic [6:0] LEGAL_TAPS [NUM_TAPS] =
        '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};

    // The decrypt side always strips at least ten leading spaces.
    function automatic logic [3:0] clamp_pre(input logic [3:0] raw);
        return (raw < PRE_MIN) ? PRE_MIN : raw;
    endfunction

endpackage

// File: rtl/lfsr_encrypt_engine_if.sv
// Start/Ack launch handshake plus the data-memory read/write ports.
interface lfsr_encrypt_engine_if;

    logic       Start;
    logic       Ack;
    logic [7:0] mem_rd_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_addr;
    logic [7:0] mem_wr_data;

    modport master (
        input  Start,
        input  mem_rd_data,
        output Ack,
        output mem_rd_addr,
        output mem_wr_en,
        output mem_wr_addr,
        output mem_wr_data
    );

    modport slave (
        output Start,
        output mem_rd_data,
        input  Ack,
        input  mem_rd_addr,
        input  mem_wr_en,
        input  mem_wr_addr,
        input  mem_wr_data
    );

endinterface

// File: rtl/lfsr_encrypt_engine_lfsr7.sv
// 7-bit Fibonacci-style LFSR: shifts left, feedback is the parity of the
// tapped bits. A zero seed is forced to 1 so the sequence never locks up.
module lfsr7 (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [6:0] init,
    input  logic       advance,
    input  logic [6:0] ptrn,
    output logic [6:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= 7'h00;
        end else if (load) begin
            state <= (init == 7'h00) ? 7'h01 : init;
        end else if (advance) begin
            state <= {state[5:0], ^(state & ptrn)};
        end
    end

endmodule

// File: rtl/lfsr_encrypt_engine.sv
// Encryption stage: reads config and plaintext from DM, writes the 64-byte
// space-padded, LFSR-scrambled, parity-tagged image to DM[64..127].
module lfsr_encrypt_engine
    import enc_pkg::*;
(
    input  logic                        Clk,
    input  logic                        Reset,
    lfsr_encrypt_engine_if.master       bus
);

    state_t     state_q;
    state_t     state_d;
    logic       start_q;
    logic [3:0] pre_q;
    logic [6:0] ptrn_q;
    logic [6:0] idx_q;

    logic [6:0] lfsr_state;
    logic       lfsr_load;
    logic       lfsr_adv;

    logic [6:0] off;
    logic       is_space;
    logic [6:0] pt;
    logic [6:0] enc;

    logic       ack;
    logic [7:0] rd_addr;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    lfsr7 u_lfsr (
        .clk     (Clk),
        .rst     (Reset),
        .load    (lfsr_load),
        .init    (bus.mem_rd_data[6:0]),
        .advance (lfsr_adv),
        .ptrn    (ptrn_q),
        .state   (lfsr_state)
    );

    // Position within the message once the leading spaces have been emitted;
    // wraps negative while idx < pre, which the idx<pre test covers.
    assign off      = idx_q - {3'b000, pre_q};
    assign is_space = (idx_q < {3'b000, pre_q}) || (off >= MAX_MSG);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            start_q <= 1'b1;
            pre_q   <= 4'd0;
            ptrn_q  <= 7'd0;
            idx_q   <= 7'd0;
        end else begin
            state_q <= state_d;
            start_q <= bus.Start;
            case (state_q)
                CFG0:    pre_q  <= clamp_pre(bus.mem_rd_data[3:0]);
                CFG1:    ptrn_q <= bus.mem_rd_data[6:0];
                CFG2:    idx_q  <= 7'd0;
                ENC:     idx_q  <= idx_q + 7'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        ack       = 1'b0;
        rd_addr   = 8'd0;
        wr_en     = 1'b0;
        wr_addr   = 8'd0;
        wr_data   = 8'd0;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        pt        = SPACE[6:0];
        enc       = 7'd0;
        case (state_q)
            IDLE: begin
                if (start_q && !bus.Start) state_d = CFG0;
            end
            CFG0: begin
                rd_addr = CFG_PRE;
                state_d = CFG1;
            end
            CFG1: begin
                rd_addr = CFG_PTRN;
                state_d = CFG2;
            end
            CFG2: begin
                rd_addr   = CFG_INIT;
                lfsr_load = 1'b1;
                state_d   = ENC;
            end
            ENC: begin
                if (!is_space) begin
                    rd_addr = MSG_BASE + {1'b0, off};
                    pt      = bus.mem_rd_data[6:0];
                end
                enc      = pt ^ lfsr_state;
                wr_en    = 1'b1;
                wr_addr  = OUT_BASE + {1'b0, idx_q};
                wr_data  = {^enc, enc};
                lfsr_adv = 1'b1;
                if (idx_q == LAST_IDX) state_d = DONE;
            end
            DONE: begin
                ack = 1'b1;
                if (bus.Start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Ack         = ack;
    assign bus.mem_rd_addr = rd_addr;
    assign bus.mem_wr_en   = wr_en;
    assign bus.mem_wr_addr = wr_addr;
    assign bus.mem_wr_data = wr_data;

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// Self-checking bench: a DM model, a per-byte reference image computed from
// the encryption rules, and a negedge compare process on every write cycle.
module tb_lfsr_encrypt_engine;
    import enc_pkg::*;

    logic Clk = 1'b0;
    logic Reset = 1'b1;

    lfsr_encrypt_engine_if bus ();

    lfsr_encrypt_engine dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;

    logic [7:0] dm [256];
    logic [7:0] exp_img [64];
    int         exp_rd [64];
    int         rd_seen [64];
    int         wr_cnt = 0;
    bit         expect_writes = 1'b0;

    assign bus.mem_rd_data = dm[bus.mem_rd_addr];

    always @(posedge Clk) begin
        if (bus.mem_wr_en) dm[bus.mem_wr_addr] = bus.mem_wr_data;
    end

    task automatic checkOutput(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference image straight from the rules: pad, scramble, tag parity.
    function automatic void compute_model();
        int pre;
        int tap;
        int l;
        int pt;
        int e;
        pre = dm[CFG_PRE] & 15;
        if (pre < 10) pre = 10;
        tap = dm[CFG_PTRN] & 8'h7F;
        l   = dm[CFG_INIT] & 8'h7F;
        if (l == 0) l = 1;
        for (int i = 0; i < 64; i++) begin
            if (i < pre || (i - pre) >= 49) begin
                pt = 8'h20;
                exp_rd[i] = -1;
            end else begin
                pt = dm[i - pre];
                exp_rd[i] = i - pre;
            end
            e = (pt & 8'h7F) ^ l;
            if ($countones(e[6:0]) % 2 == 1) e = e | 8'h80;
            exp_img[i] = e[7:0];
            l = ((l << 1) & 8'h7F) | ($countones(l & tap) % 2);
        end
    endfunction

    always @(negedge Clk) begin
        if (!Reset && bus.mem_wr_en) begin
            if (!expect_writes || wr_cnt >= 64) begin
                checkOutput("unexpected_write", 1, 0);
            end else begin
                rd_seen[wr_cnt] = int'(bus.mem_rd_addr);
                checkOutput($sformatf("wr_addr[%0d]", wr_cnt), bus.mem_wr_addr, 64 + wr_cnt);
                checkOutput($sformatf("wr_data[%0d]", wr_cnt), bus.mem_wr_data, exp_img[wr_cnt]);
                if (exp_rd[wr_cnt] >= 0)
                    checkOutput($sformatf("rd_addr[%0d]", wr_cnt), bus.mem_rd_addr, exp_rd[wr_cnt]);
                wr_cnt++;
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] pre_b, input logic [7:0] ptrn_b,
                                 input logic [7:0] init_b);
        for (int i = 0; i < 61; i++) dm[i] = 8'($urandom);
        for (int i = 64; i < 128; i++) dm[i] = 8'($urandom);
        dm[CFG_PRE]  = pre_b;
        dm[CFG_PTRN] = ptrn_b;
        dm[CFG_INIT] = init_b;
    endtask

    task automatic loadString(input string s);
        for (int i = 0; i < s.len(); i++) dm[i] = s[i];
    endtask

    task automatic pulseReset();
        @(negedge Clk);
        Reset = 1'b1;
        bus.Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic checkImage(input string name);
        int nbad;
        nbad = 0;
        for (int i = 0; i < 64; i++) if (dm[64 + i] !== exp_img[i]) nbad++;
        checkOutput(name, nbad, 0);
    endtask

    task automatic launchAndRun(input bit toggle_start);
        int cyc;
        compute_model();
        wr_cnt = 0;
        expect_writes = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        @(posedge Clk);
        cyc = 1;
        while (cyc <= 200) begin
            @(negedge Clk);
            if (bus.Ack) break;
            if (toggle_start && cyc >= 10 && cyc <= 40) bus.Start = 1'($urandom_range(0, 1));
            if (toggle_start && cyc == 41) bus.Start = 1'b1;
            @(posedge Clk);
            cyc++;
        end
        checkOutput("ack_cycle", cyc, 68);
        checkOutput("write_count", wr_cnt, 64);
        if (cyc > 200) begin
            expect_writes = 1'b0;
            pulseReset();
        end else begin
            if (!toggle_start) begin
                repeat (3) begin
                    @(posedge Clk);
                    @(negedge Clk);
                    checkOutput("ack_hold", bus.Ack, 1);
                end
                bus.Start = 1'b1;
            end
            expect_writes = 1'b0;
            @(posedge Clk);
            @(negedge Clk);
            checkOutput("ack_drop", bus.Ack, 0);
        end
        checkImage("image");
    endtask

    initial begin
        int cnt;
        bus.Start = 1'b1;
        for (int i = 0; i < 256; i++) dm[i] = 8'h00;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checkOutput("rst_ack", bus.Ack, 0);
        checkOutput("rst_wr_en", bus.mem_wr_en, 0);
        checkOutput("rst_rd_addr", bus.mem_rd_addr, 0);
        checkOutput("rst_wr_addr", bus.mem_wr_addr, 0);
        checkOutput("rst_wr_data", bus.mem_wr_data, 0);
        Reset = 1'b0;

        $display("[TB] known-answer run");
        applyStimulus(8'd14, 8'h7B, 8'd49);
        loadString("Mr. Watson, come here. I want to see you.");
        launchAndRun(1'b0);
        checkOutput("kat_dm64", dm[64], 8'h11);
        checkOutput("kat_dm65", dm[65], 8'hC3);

        $display("[TB] zero seed");
        applyStimulus(8'd10, 8'h60, 8'd0);
        launchAndRun(1'b0);
        checkOutput("zero_seed_dm64", dm[64], 8'h21);

        $display("[TB] pre clamp");
        applyStimulus(8'd3, LEGAL_TAPS[2], 8'h5A);
        launchAndRun(1'b0);
        checkOutput("clamp_first_msg_rd", rd_seen[10], 0);

        $display("[TB] long message pre=15");
        applyStimulus(8'd15, LEGAL_TAPS[4], 8'h33);
        launchAndRun(1'b0);
        checkOutput("last_msg_rd", rd_seen[63], 48);

        $display("[TB] reset during ENC");
        applyStimulus(8'd12, LEGAL_TAPS[7], 8'h2C);
        compute_model();
        wr_cnt = 0;
        expect_writes = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        cnt = 0;
        while (cnt < 200 && !(bus.mem_wr_en && bus.mem_wr_addr == 8'd84)) begin
            @(negedge Clk);
            cnt++;
        end
        checkOutput("reached_idx20", cnt < 200 ? 1 : 0, 1);
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        expect_writes = 1'b0;
        checkOutput("mid_rst_wr_en", bus.mem_wr_en, 0);
        checkOutput("mid_rst_ack", bus.Ack, 0);
        checkOutput("mid_rst_wr_addr", bus.mem_wr_addr, 0);
        Reset = 1'b0;
        bus.Start = 1'b1;
        repeat (10) @(negedge Clk);
        for (int i = 64; i < 128; i++) dm[i] = 8'($urandom);
        launchAndRun(1'b0);

        $display("[TB] start toggles during ENC, then rerun");
        applyStimulus(8'd11, LEGAL_TAPS[0], 8'h7F);
        launchAndRun(1'b1);
        cnt = 0;
        repeat (20) begin
            @(negedge Clk);
            if (bus.Ack || bus.mem_wr_en) cnt++;
        end
        checkOutput("no_relaunch", cnt, 0);
        for (int i = 64; i < 128; i++) dm[i] = 8'($urandom);
        launchAndRun(1'b0);

        $display("[TB] reset coincides with launch");
        @(negedge Clk);
        Reset = 1'b1;
        bus.Start = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        bus.Start = 1'b1;
        cnt = 0;
        repeat (80) begin
            @(negedge Clk);
            if (bus.Ack || bus.mem_wr_en) cnt++;
        end
        checkOutput("reset_beats_launch", cnt, 0);

        $display("[TB] random runs");
        for (int r = 0; r < 6; r++) begin
            logic [7:0] tp;
            logic [7:0] seed;
            tp   = (r % 2 == 0) ? {1'b0, LEGAL_TAPS[$urandom_range(0, NUM_TAPS - 1)]} : 8'($urandom);
            seed = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
            applyStimulus(8'($urandom), tp, seed);
            launchAndRun(1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_encrypt_engine.md
Name: lfsr_encrypt_engine

Overview:
- Hardware encryption stage. Reads a plaintext message plus a configuration block from data memory.
- Prepends `pre_length` ASCII spaces and pads the tail with spaces to 64 bytes.
- XORs each byte with a 7-bit maximal-length LFSR sequence and writes the bit-6:0 parity into bit 7.
- Stores the 64 encrypted bytes at DM[64..127], the exact image the decrypt/depad program consumes.
- Sits directly upstream of the program-3 decrypt flow and shares the TopLevel Start/Ack launch protocol.

Parameters:
- MSG_BASE, 0, DM address of plaintext byte 0
- CFG_PRE, 61, DM address of pre_length
- CFG_PTRN, 62, DM address of LFSR tap pattern
- CFG_INIT, 63, DM address of LFSR start state
- OUT_BASE, 64, DM address of encrypted byte 0
- NUM_OUT, 64, encrypted bytes produced
- MAX_MSG, 49, plaintext bytes eligible for copy

Ports:
- Clk, in, 1, single clock, rising edge
- Reset, in, 1, synchronous active-high reset
- Start, in, 1, held high = hold; a 1->0 transition launches a run
- Ack, out, 1, run complete
- mem_rd_addr, out, 8, DM read address
- mem_rd_data, in, 8, DM read data, combinational (same cycle)
- mem_wr_en, out, 1, DM write enable, written on rising edge
- mem_wr_addr, out, 8, DM write address
- mem_wr_data, out, 8, DM write data

Behaviour:
- Reset values (Reset high at a rising edge, from any state, mid-run included): state=IDLE, Ack=0, mem_wr_en=0, mem_rd_addr=0, mem_wr_addr=0, mem_wr_data=0, idx=0, lfsr=0, start_q=1.
- start_q registers Start each cycle. A launch occurs when start_q=1 and Start=0 while in IDLE. Start toggles in any other state are ignored, except in DONE (below).
- States and transitions:
  - IDLE -> CFG0 on launch.
  - CFG0: rd_addr=CFG_PRE. Latch pre = clamp(rd_data[3:0], 10..15): values <10 become 10, values >15 cannot occur in 4 bits. -> CFG1.
  - CFG1: rd_addr=CFG_PTRN. Latch ptrn=rd_data[6:0]. -> CFG2.
  - CFG2: rd_addr=CFG_INIT. Latch lfsr=rd_data[6:0], with 0 replaced by 7'h01. idx=0. -> ENC.
  - ENC, one byte per cycle:
    - off = idx - pre, 7-bit arithmetic.
    - pt = 8'h20 if idx<pre or off>=MAX_MSG; otherwise rd_data with rd_addr=MSG_BASE+off. rd_addr is don't-care when pt is a space.
    - e[6:0] = pt[6:0] ^ lfsr; e[7] = ^e[6:0]. pt[7] is discarded.
    - Drive wr_en=1, wr_addr=OUT_BASE+idx, wr_data=e.
    - lfsr <= {lfsr[5:0], ^(lfsr & ptrn)}; idx <= idx+1.
    - After idx=NUM_OUT-1 is written -> DONE.
  - DONE: Ack=1, wr_en=0. Start=1 -> IDLE with Ack=0 next cycle; Ack holds until then.
- Latency: launch edge + 3 cfg cycles + 64 ENC cycles. Ack rises on cycle 68 after the launch edge. No stalls.
- idx is 7 bits. No wrap: ENC exits at 63, so addresses never exceed 127.
- No read/write collisions: reads target 0..63, writes target 64..127.
- Tap pattern is not validated; any value is accepted.
- If Reset and launch coincide, Reset wins.

Decomposition:
- Package enc_pkg:
  - state enum {IDLE, CFG0, CFG1, CFG2, ENC, DONE}
  - address constants
  - SPACE = 8'h20
  - the 9 legal tap patterns 7'h60, 48, 78, 72, 6A, 69, 5C, 7E, 7B (bench use)
- Sub-module lfsr7: 7-bit register with load (init, zero->1), advance, and ptrn input; output state.

Test Plan:
- ptrn=7'h7B, init=49, pre=14, msg "Mr. Watson, come here. I want to see you.", launch -> DM[64]=8'h11, DM[65]=8'hC3; all 64 bytes match the bench model; Ack at cycle 68.
- init=0, ptrn=7'h60, pre=10 -> LFSR starts at 7'h01; DM[64]=8'h21.
- pre=3 in DM[61] -> treated as 10: DM[64+9] encrypts a space, DM[64+10] encrypts msg[0].
- 60-char message region, pre=15 -> bytes at idx>=15+49=64 do not exist; idx 15..63 copy msg[0..48]; msg[49..] never read (verify rd_addr never >48 while used).
- Reset pulsed at ENC idx=20 -> next cycle wr_en=0, Ack=0, state IDLE. A fresh launch then produces a complete, correct image.
- Hold Start=1 after Ack; toggle Start during ENC -> no relaunch and output unaffected. Start 0->1 in DONE drops Ack; a second 1->0 re-runs and gives an identical result.
